// File: rtl/sched_tx_sec.sv
// Transmit scheduler for the serial sequence-detector link. It round-robins
// 5-bit words from two requesters into frames of the form sync, words, restart.
//
// state  | meaning
// IDLE   | line at SEP, waiting for any request
// PRE    | shifting out SECUENCIA, MSB first
// SEPB   | separator bit; arbitration and word capture happen here
// DATOS  | shifting out the captured word, MSB first
// CIERRE | shifting out SEC_REINICIO, then back to IDLE
module sched_tx_sec #(
   parameter logic [4:0] SECUENCIA    = 5'b10100,
   parameter logic [4:0] SEC_REINICIO = 5'b00000,
   parameter logic       SEP          = 1'b1,
   parameter int         WORDS_MAX    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic [4:0] dat_a,
   output logic       gnt_a,
   input  logic       req_b,
   input  logic [4:0] dat_b,
   output logic       gnt_b,
   output logic       s_out,
   output logic       activo,
   output logic       err_palabra
);

   localparam logic [3:0] WMAX = 4'(WORDS_MAX);

   typedef enum logic [2:0] {IDLE, PRE, SEPB, DATOS, CIERRE} state_t;

   state_t     state, state_nxt;
   logic [2:0] bit_idx, bit_nxt;
   logic [3:0] n_words, n_words_nxt;
   logic       rr_b, rr_b_nxt;
   logic [4:0] word, word_nxt;
   logic [4:0] sel_word;
   logic       pick_b;
   logic       s_out_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_idx <= 3'd0;
         n_words <= 4'd0;
         rr_b    <= 1'b0;
         word    <= 5'd0;
         s_out   <= SEP;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_nxt;
         n_words <= n_words_nxt;
         rr_b    <= rr_b_nxt;
         word    <= word_nxt;
         s_out   <= s_out_nxt;
      end
   end

   assign activo = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      bit_nxt     = bit_idx;
      n_words_nxt = n_words;
      rr_b_nxt    = rr_b;
      word_nxt    = word;
      gnt_a       = 1'b0;
      gnt_b       = 1'b0;
      err_palabra = 1'b0;
      pick_b      = 1'b0;
      sel_word    = dat_a;
      case (state)
         IDLE: begin
            if (req_a || req_b) begin
               state_nxt   = PRE;
               bit_nxt     = 3'd4;
               n_words_nxt = 4'd0;
            end
         end
         PRE: begin
            if (bit_idx == 3'd0) state_nxt = SEPB;
            else                 bit_nxt   = bit_idx - 3'd1;
         end
         SEPB: begin
            if ((n_words == WMAX) || !(req_a || req_b)) begin
               state_nxt = CIERRE;
               bit_nxt   = 3'd4;
            end else begin
               pick_b   = req_b && (!req_a || rr_b);
               gnt_a    = !pick_b;
               gnt_b    = pick_b;
               rr_b_nxt = !pick_b;
               sel_word = pick_b ? dat_b : dat_a;
               // a restart pattern is consumed but never sent; stay for another SEP bit
               if (sel_word == SEC_REINICIO) begin
                  err_palabra = 1'b1;
               end else begin
                  word_nxt    = sel_word;
                  n_words_nxt = n_words + 4'd1;
                  state_nxt   = DATOS;
                  bit_nxt     = 3'd4;
               end
            end
         end
         DATOS: begin
            if (bit_idx == 3'd0) state_nxt = SEPB;
            else                 bit_nxt   = bit_idx - 3'd1;
         end
         CIERRE: begin
            if (bit_idx == 3'd0) state_nxt = IDLE;
            else                 bit_nxt   = bit_idx - 3'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // line value is registered from the upcoming state so it lines up with it
   always_comb begin
      s_out_nxt = SEP;
      case (state_nxt)
         PRE:     s_out_nxt = SECUENCIA[bit_nxt];
         DATOS:   s_out_nxt = word_nxt[bit_nxt];
         CIERRE:  s_out_nxt = SEC_REINICIO[bit_nxt];
         default: s_out_nxt = SEP;
      endcase
   end

endmodule
